fifo_lane_packer: RTL and testbench
===================================

Name: fifo_lane_packer

Overview:
- Downstream consumer of the single-entry pipeline FIFO.
- Pops W-bit entries through the FIFO's empty/rdata/re interface.
- Packs K consecutive entries into one W*K-bit word and presents it on a valid/ready output.
- A flush input emits a partially filled word, so the tail of a stream is never stranded.

Parameters:
- W, 8, width of one FIFO entry (lane width).
- K, 4, lanes per packed output word; K >= 2.
- CW, $clog2(K+1), width of lane-count fields (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_empty  input  1  upstream FIFO empty flag.
- in_data  input  W  upstream FIFO read data; valid when in_empty=0.
- in_re  output  1  pop strobe to upstream FIFO.
- flush  input  1  request to emit the current partial word.
- out_valid  output  1  packed word available.
- out_data  output  W*K  packed word; lane 0 = bits [W-1:0].
- out_count  output  CW  number of valid lanes in out_data (1..K).
- out_ready  input  1  downstream accepts word when out_valid=1.

Behaviour:
- Reset (async, rst_n=0):
  - fill count = 0, accumulator = 0.
  - out_valid = 0, out_data = 0, out_count = 0.
  - in_re forced to 0 while rst_n=0.
  - Reset mid-word discards all partial lanes.
- Handshake and pop rule:
  - Output accepted ("fire") when out_valid && out_ready.
  - in_re = !in_empty && (!out_valid || out_ready). Purely combinational.
  - in_re is never asserted while in_empty=1.
  - A pop captures in_data into lane[fill], then fill increments.
- Full word:
  - When a pop brings fill to K, the complete word transfers to the output registers on that edge.
  - out_valid=1, out_count=K, fill returns to 0.
  - Latency: the K-th pop's edge produces out_valid=1 in the next cycle.
- Output holding:
  - Output registers are a single slot.
  - out_data and out_count stay stable while out_valid && !out_ready.
  - No pops occur while the slot is full and not firing.
- Simultaneous fire and pop:
  - Pop proceeds into the accumulator, with no bubble.
  - If that pop completes a word, the new word replaces the fired one on the same edge and out_valid stays 1.
  - Full throughput is one entry per cycle; one packed word every K cycles.
- Flush:
  - Sampled each cycle; acts only when the output slot is free or firing.
  - Effective lane count = fill + (pop this cycle ? 1 : 0).
  - If effective count > 0: emit the accumulator including any lane popped this cycle. out_count = effective count, unused upper lanes = 0, fill reset to 0.
  - If effective count = 0: flush is ignored and no empty word is produced.
  - If the slot is blocked (out_valid && !out_ready): flush has no effect that cycle. The requester holds flush until accepted.
  - If effective count reaches K with flush asserted, the result is identical to a normal full word.
- Accumulator:
  - Lanes not yet written read 0.
  - Accumulator is cleared whenever it transfers to output.
- Arithmetic:
  - fill is CW bits and never exceeds K-1 between cycles.
  - out_count width is CW; K itself must be representable.

Test Plan:
- Reset then stream bytes 0x11,0x22,0x33,0x44 with in_empty=0 and out_ready=1 -> in_re high 4 cycles; out_valid=1 one cycle later; out_data=0x44332211; out_count=4.
- Continuous 8 bytes 0x01..0x08, out_ready=1 -> two words 0x04030201 and 0x08070605; in_re never drops; no gap between words.
- Fill word 0xDDCCBBAA, hold out_ready=0 for 5 cycles while the FIFO keeps data -> out_data stable; in_re=0 throughout; on out_ready=1, pop resumes in that same cycle.
- Pop 0xA1,0xB2, then flush=1 with in_empty=1 -> out_valid=1; out_data=0x0000B2A1; out_count=2; a later flush with nothing buffered produces no word.
- Pop 0x10,0x20, then a cycle with pop 0x30 and flush=1 together -> out_data=0x00302010; out_count=3; fill=0 afterwards.
- Pop 3 lanes, assert rst_n=0 for one cycle, then stream 0x55,0x66,0x77,0x88 -> all outputs 0 during reset; first word after reset is 0x88776655 with no stale lanes.

Source files
------------

// File: rtl/fifo_lane_packer.sv
`default_nettype none
// ============================================================================
// fifo_lane_packer - packs K popped W-bit FIFO entries into one valid/ready word
// Revision: 1.0
// ============================================================================
module fifo_lane_packer #(
    parameter int W  = 8,
    parameter int K  = 4,
    parameter int CW = $clog2(K + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_empty,
    input  logic [W-1:0]    in_data,
    output logic            in_re,
    input  logic            flush,
    output logic            out_valid,
    output logic [W*K-1:0]  out_data,
    output logic [CW-1:0]   out_count,
    input  logic            out_ready
);

    localparam logic [CW-1:0] c_last_lane = CW'(K - 1);
    localparam logic [CW-1:0] c_one       = CW'(1);

    logic [CW-1:0]  r_fill;
    logic [W*K-1:0] r_acc;
    logic           r_out_valid;
    logic [W*K-1:0] r_out_data;
    logic [CW-1:0]  r_out_count;

    logic           w_slot_free;
    logic           w_pop;
    logic           w_word_done;
    logic           w_emit;
    logic [CW-1:0]  w_eff;
    logic [W*K-1:0] w_acc_next;

    assign w_slot_free = !r_out_valid || out_ready;
    // rst_n gates the pop so the upstream FIFO is never drained during reset
    assign w_pop       = rst_n && !in_empty && w_slot_free;
    assign w_eff       = w_pop ? (r_fill + c_one) : r_fill;
    assign w_word_done = w_pop && (r_fill == c_last_lane);
    assign w_emit      = w_slot_free && (w_word_done || (flush && (w_eff != '0)));

    assign in_re     = w_pop;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // Accumulator view including a lane popped this cycle, so flush can emit it
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < K; i++) begin
            if (w_pop && (r_fill == CW'(i))) begin
                w_acc_next[i*W +: W] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
                r_out_count <= w_eff;
                r_acc       <= '0;
                r_fill      <= '0;
            end else begin
                if (w_slot_free) begin
                    r_out_valid <= 1'b0;
                end
                if (w_pop) begin
                    r_acc  <= w_acc_next;
                    r_fill <= r_fill + c_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_lane_packer.sv
`default_nettype none
// Testbench for fifo_lane_packer: directed scenarios plus random traffic
// checked against a queue-based lane model.
module tb_fifo_lane_packer;

    localparam int W  = 8;
    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_empty;
    logic [W-1:0]   in_data;
    logic           in_re;
    logic           flush;
    logic           out_valid;
    logic [W*K-1:0] out_data;
    logic [CW-1:0]  out_count;
    logic           out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: buffered lanes as a queue, output slot as plain state
    logic [W-1:0]   m_acc[$];
    logic           m_valid;
    logic [W*K-1:0] m_data;
    logic [CW-1:0]  m_count;
    logic           m_re;

    fifo_lane_packer #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .in_re     (in_re),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_acc.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_count = '0;
        m_re    = 1'b0;
    endtask

    task automatic drive(input logic e, input logic [W-1:0] d, input logic f, input logic r);
        in_empty  = e;
        in_data   = d;
        flush     = f;
        out_ready = r;
        m_re      = rst_n && !e && (!m_valid || r);
    endtask

    task automatic tick();
        logic slot_free;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            slot_free = !m_valid || out_ready;
            if (m_re) m_acc.push_back(in_data);
            if (slot_free) begin
                if (m_acc.size() == K || (flush && m_acc.size() > 0)) begin
                    m_data = '0;
                    foreach (m_acc[i]) m_data[i*W +: W] = m_acc[i];
                    m_count = CW'(m_acc.size());
                    m_valid = 1'b1;
                    m_acc.delete();
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h5A, 1'b1, 1'b1);
        rst_n = 1'b0;
        model_clear();
        #1;
        n_vec++;
        if (in_re !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin
            n_err++;
            $display("FAIL reset: in_re=%b valid=%b data=%h count=%0d, required all 0",
                     in_re, out_valid, out_data, out_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_stream();
        logic [W-1:0] bytes_in[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, bytes_in[i], 1'b0, 1'b1);
            #1;
            n_vec++;
            if (in_re !== 1'b1) begin
                n_err++;
                $display("FAIL stream_re[%0d]: got %b, required 1", i, in_re);
            end
            tick();
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_count !== 3'd4) begin
            n_err++;
            $display("FAIL stream_word: valid=%b data=%h count=%0d, required 1 44332211 4",
                     out_valid, out_data, out_count);
        end
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, W'(i + 1), 1'b0, 1'b1);
            #1;
            n_vec++;
            if (in_re !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_re[%0d]: got %b, required 1", i, in_re);
            end
            tick();
            n_vec++;
            if (out_valid !== (i == 3 || i == 7)) begin
                n_err++;
                $display("FAIL b2b_valid[%0d]: got %b, required %b", i, out_valid, (i == 3 || i == 7));
            end
            if (i == 3 && out_data !== 32'h04030201) begin
                n_err++;
                $display("FAIL b2b_word0: got %h, required 04030201", out_data);
            end
            if (i == 7 && out_data !== 32'h08070605) begin
                n_err++;
                $display("FAIL b2b_word1: got %h, required 08070605", out_data);
            end
        end
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] bytes_in[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, bytes_in[i], 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'hEE, 1'b0, 1'b0);
            #1;
            n_vec++;
            if (in_re !== 1'b0) begin
                n_err++;
                $display("FAIL bp_re[%0d]: got %b, required 0", i, in_re);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 32'hDDCCBBAA || out_count !== 3'd4) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h count=%0d, required 1 ddccbbaa 4",
                         i, out_valid, out_data, out_count);
            end
        end
        drive(1'b0, 8'hEE, 1'b0, 1'b1);
        #1;
        n_vec++;
        if (in_re !== 1'b1) begin
            n_err++;
            $display("FAIL bp_resume: in_re=%b, required 1", in_re);
        end
        tick();
        drive(1'b1, 8'h00, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h000000EE || out_count !== 3'd1) begin
            n_err++;
            $display("FAIL bp_tail: valid=%b data=%h count=%0d, required 1 000000ee 1",
                     out_valid, out_data, out_count);
        end
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b0, 8'hA1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'hB2, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b1, 1'b1);
        #1;
        n_vec++;
        if (in_re !== 1'b0) begin
            n_err++;
            $display("FAIL flush_re: got %b with empty FIFO, required 0", in_re);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000B2A1 || out_count !== 3'd2) begin
            n_err++;
            $display("FAIL flush_word: valid=%b data=%h count=%0d, required 1 0000b2a1 2",
                     out_valid, out_data, out_count);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h00, 1'b1, 1'b1);
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_empty[%0d]: valid=%b, required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_flush_with_pop();
        drive(1'b0, 8'h10, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h20, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h30, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h00302010 || out_count !== 3'd3) begin
            n_err++;
            $display("FAIL flushpop_word: valid=%b data=%h count=%0d, required 1 00302010 3",
                     out_valid, out_data, out_count);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, W'(8'h41 + i), 1'b0, 1'b1);
            tick();
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h44434241 || out_count !== 3'd4) begin
            n_err++;
            $display("FAIL flushpop_next: valid=%b data=%h count=%0d, required 1 44434241 4",
                     out_valid, out_data, out_count);
        end
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] bytes_in[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, W'(8'h99 + i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'hC3, 1'b0, 1'b1);
        rst_n = 1'b0;
        model_clear();
        #1;
        n_vec++;
        if (in_re !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_count !== '0) begin
            n_err++;
            $display("FAIL midreset: in_re=%b valid=%b data=%h count=%0d, required all 0",
                     in_re, out_valid, out_data, out_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, bytes_in[i], 1'b0, 1'b1);
            tick();
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h88776655 || out_count !== 3'd4) begin
            n_err++;
            $display("FAIL midreset_word: valid=%b data=%h count=%0d, required 1 88776655 4",
                     out_valid, out_data, out_count);
        end
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 3, W'($urandom), $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 7);
            #1;
            n_vec++;
            if (in_re !== m_re) begin
                n_err++;
                $display("FAIL rand_re[%0d]: got %b, required %b", i, in_re, m_re);
            end
            tick();
            n_vec++;
            if (out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_count !== m_count))) begin
                n_err++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h count=%0d, required %b %h %0d",
                         i, out_valid, out_data, out_count, m_valid, m_data, m_count);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        apply_reset();
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_flush_with_pop();
        test_reset_midword();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
